lc3b_bus_arbiter: RTL and testbench
===================================

# lc3b_bus_arbiter

Round-robin arbiter that shares the processor's 16-bit internal bus among eight drivers, and drives the 3-bit select of the bus's 8-input 16-bit mux. Requesters (PC, ALU, shifter, MDR, MARMUX and spare slots) raise a request and hold it for as many cycles as they need the bus. The arbiter issues a registered one-hot grant and a matching select code, and rotates priority for fairness. An optional tenure limit is available to prevent bus hogging.

## Interface
Parameters:
- NUM_SRC, 8: number of requesters; fixed at 8 to match the 3-bit mux select.
- MAX_TENURE, 16: maximum consecutive grant cycles before forced rotation; must be ≥2. Used only with BUS_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i means source i wants the bus; held high for the whole transfer.
- grant  output  8  one-hot grant, registered; all-zero when idle.
- sel  output  3  binary index of the granted source, fed to the mux select; registered.
- bus_valid  output  1  high when any grant is active (OR of grant).
- preempt  output  1  one-cycle pulse on the edge at which a holder loses the bus by timeout. Tied 0 without BUS_ARB_TIMEOUT_EN.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: one source holds grant.
- Priority pointer `last` (3 bits) holds the index of the most recent grantee. Search order is last+1, last+2, …, last+8, all mod 8; the first set req bit wins.
- IDLE → BUSY: any req bit set. Winner w is chosen by the search; grant←(1<<w), sel←w, last←w.
- BUSY, holder h keeps req[h]=1: grant is unchanged (lock). req changes from other sources are ignored.
- BUSY, req[h]=0 and another source pending: switch directly to the next winner with no idle cycle. Search starts from h+1.
- BUSY, req[h]=0 and no other source pending: → IDLE, grant←0, bus_valid←0. sel holds its last value (no mux toggling).
- Simultaneous requests: exactly one grant per edge; others wait.
- req of a source deasserted before it is granted: it is simply not selected.
- Reset (asynchronous, any time, including mid-transfer):
  - grant=0, sel=0, bus_valid=0, preempt=0, state=IDLE.
  - last=7, so source 0 has top priority.
  - Tenure counter=0.

## Timing
- Grant latency: req sampled at edge N gives grant/sel valid after edge N; the earliest bus cycle is N+1.
- Release latency: req[h] low before edge N gives grant[h] low after edge N. The next grant appears on the same edge.
- sel and grant change only on clock edges. They are never combinationally derived from req.
- Invariant: grant is zero or one-hot; when bus_valid=1, grant[sel]=1.
- Tenure counter (timeout build):
  - Resets to 0 on every new grant.
  - Increments each BUSY cycle and saturates at MAX_TENURE-1.

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - While counter==MAX_TENURE-1, req[h]=1 and some other req set, the next edge moves the grant to the next winner (search from h+1) and pulses preempt for one cycle.
  - A preempted source keeping req high re-competes normally.
  - With no other request pending, the holder keeps the bus indefinitely.
- Not defined:
  - No counter logic and no preemption.
  - preempt is constant 0.
  - The holder keeps the bus until it drops req.

## Structure
- Package lc3b_bus_pkg:
  - NUM_SRC=8 and SEL_W=3.
  - Source index constants (SRC_PC, SRC_ALU, SRC_SHF, SRC_MDR, SRC_MARMUX, SRC_SPARE5..7).
  - State enum {ARB_IDLE, ARB_BUSY}.
- Sub-module rr_pick8: combinational rotating-priority encoder.
  - Inputs: req[7:0] and start[2:0].
  - Outputs: found and idx[2:0].
- The top level holds the state register, pointer, tenure counter and output registers.

## Test plan
- Reset with req=8'hFF: after the first edge, grant=8'h01, sel=0, bus_valid=1. Asserting rst_n=0 mid-grant immediately gives grant=0, sel=0, bus_valid=0.
- Fairness: req=8'hFF, each holder drops req for one cycle after 2 cycles of tenure and then re-raises it. Grant order must be 0,1,2,…,7,0 with no idle gap between grants.
- Lock: source 3 granted; source 1 raises req mid-transfer. grant stays 8'h08 until req[3] falls, then grant=8'h02 and sel=1 on that edge.
- Idle hold: a single source 5 transfer ends. grant=0, bus_valid=0, sel stays 5. A later req[2] gives sel=2 one edge later.
- Timeout (BUS_ARB_TIMEOUT_EN, MAX_TENURE=4): req=8'h11 held constant. Grant alternates 0↔4 every 4 cycles, with preempt pulsing at each switch.
- Build without the macro: the same stimulus keeps grant=8'h01 forever and preempt stays 0.

Source files
------------

// File: rtl/lc3b_bus_pkg.sv
// Shared constants, source indices and arbiter state type for the LC-3b internal bus.
package lc3b_bus_pkg;

  localparam int NUM_SRC = 8;
  localparam int SEL_W   = 3;

  localparam logic [SEL_W-1:0] SRC_PC     = 3'd0;
  localparam logic [SEL_W-1:0] SRC_ALU    = 3'd1;
  localparam logic [SEL_W-1:0] SRC_SHF    = 3'd2;
  localparam logic [SEL_W-1:0] SRC_MDR    = 3'd3;
  localparam logic [SEL_W-1:0] SRC_MARMUX = 3'd4;
  localparam logic [SEL_W-1:0] SRC_SPARE5 = 3'd5;
  localparam logic [SEL_W-1:0] SRC_SPARE6 = 3'd6;
  localparam logic [SEL_W-1:0] SRC_SPARE7 = 3'd7;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/lc3b_bus_arbiter_if.sv
// Request/grant bundle between bus drivers and the arbiter, plus arbiter state for observation.
interface lc3b_bus_arbiter_if;
  import lc3b_bus_pkg::*;

  // req is a level held for the whole transfer; grant/sel are registered and
  // change only on clk edges, so a driver owns the bus for every cycle grant[i]=1.
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] grant;
  logic [SEL_W-1:0]   sel;
  logic               bus_valid;
  logic               preempt;
  arb_state_e         state_dbg;

  modport master (
    output req,
    input  grant, sel, bus_valid, preempt, state_dbg
  );

  modport slave (
    input  req,
    output grant, sel, bus_valid, preempt, state_dbg
  );

endinterface

// File: rtl/lc3b_bus_arbiter_rr_pick8.sv
// Rotating-priority encoder: first set req bit searching start, start+1, ... (mod 8).
module rr_pick8
  import lc3b_bus_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   start,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] pos;

  // Walk from the farthest offset back to start so the nearest hit overwrites.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      pos = start + SEL_W'(i);
      if (req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/lc3b_bus_arbiter.sv
// Round-robin owner of the LC-3b internal bus mux select.
// Optional tenure limit with forced rotation: define BUS_ARB_TIMEOUT_EN.
module lc3b_bus_arbiter
  import lc3b_bus_pkg::*;
#(
  parameter int NUM_SRC    = 8,
  parameter int MAX_TENURE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  lc3b_bus_arbiter_if.slave   bus
);

  arb_state_e         state;
  logic [NUM_SRC-1:0] grant_q;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   last_q;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               unused_cfg;

  assign unused_cfg = (MAX_TENURE >= 2);

  // last always equals the current holder while busy, so one search from
  // last+1 serves idle entry, release hand-off and preemption alike.
  rr_pick8 u_pick (
    .req   (bus.req),
    .start (last_q + SEL_W'(1)),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TW = (MAX_TENURE > 2) ? $clog2(MAX_TENURE) : 1;
  localparam logic [TW-1:0] TEN_MAX = TW'(MAX_TENURE - 1);

  logic [TW-1:0] tenure;
  logic          preempt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      grant_q   <= '0;
      sel_q     <= SRC_PC;
      last_q    <= SRC_SPARE7;
      tenure    <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            state   <= ARB_BUSY;
            grant_q <= NUM_SRC'(1) << pick_idx;
            sel_q   <= pick_idx;
            last_q  <= pick_idx;
            tenure  <= '0;
          end
        end
        ARB_BUSY: begin
          if (!bus.req[sel_q]) begin
            if (pick_found) begin
              grant_q <= NUM_SRC'(1) << pick_idx;
              sel_q   <= pick_idx;
              last_q  <= pick_idx;
              tenure  <= '0;
            end else begin
              state   <= ARB_IDLE;
              grant_q <= '0;
            end
          end else if (tenure == TEN_MAX && pick_found && pick_idx != sel_q) begin
            // Holder overstayed while someone else waits: hand over now.
            grant_q   <= NUM_SRC'(1) << pick_idx;
            sel_q     <= pick_idx;
            last_q    <= pick_idx;
            tenure    <= '0;
            preempt_q <= 1'b1;
          end else if (tenure != TEN_MAX) begin
            tenure <= tenure + TW'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.preempt = preempt_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      grant_q <= '0;
      sel_q   <= SRC_PC;
      last_q  <= SRC_SPARE7;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            state   <= ARB_BUSY;
            grant_q <= NUM_SRC'(1) << pick_idx;
            sel_q   <= pick_idx;
            last_q  <= pick_idx;
          end
        end
        ARB_BUSY: begin
          // Locked until the holder drops req; sel is left alone on idle.
          if (!bus.req[sel_q]) begin
            if (pick_found) begin
              grant_q <= NUM_SRC'(1) << pick_idx;
              sel_q   <= pick_idx;
              last_q  <= pick_idx;
            end else begin
              state   <= ARB_IDLE;
              grant_q <= '0;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.preempt = 1'b0;
`endif

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.bus_valid = |grant_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_lc3b_bus_arbiter.sv
// Directed bench for lc3b_bus_arbiter; expectations switch with BUS_ARB_TIMEOUT_EN.
module tb_lc3b_bus_arbiter;
  import lc3b_bus_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [NUM_SRC-1:0] exp_q[$];

  lc3b_bus_arbiter_if bif ();

  lc3b_bus_arbiter #(
    .NUM_SRC    (8),
    .MAX_TENURE (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [NUM_SRC-1:0] v);
    bif.req = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] g, input logic [2:0] s, input logic bv);
    check({tag, ".grant"}, 32'(bif.grant), 32'(g));
    check({tag, ".sel"}, 32'(bif.sel), 32'(s));
    check({tag, ".bus_valid"}, 32'(bif.bus_valid), 32'(bv));
  endtask

  initial begin
    logic [7:0] g;
    total = 0;
    bad   = 0;
    bif.req = 8'hFF;
    rst_n   = 1'b0;
    #2;
    check_outputs("reset", 8'h00, 3'd0, 1'b0);
    check("reset.preempt", 32'(bif.preempt), 32'd0);
    check("reset.state", 32'(bif.state_dbg), 32'(ARB_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // first edge after reset: source 0 has top priority
    step();
    check_outputs("first", 8'h01, 3'd0, 1'b1);
    check("first.state", 32'(bif.state_dbg), 32'(ARB_BUSY));

    // asynchronous reset mid-grant
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // fairness: each holder keeps 2 cycles, drops req for one edge
    for (int k = 0; k < 9; k++) exp_q.push_back(8'h01 << (k % 8));
    drive_req(8'hFF);
    for (int k = 0; k < 9; k++) begin
      step();
      drive_req(8'hFF);
      g = exp_q.pop_front();
      check_outputs($sformatf("rr%0d.c1", k), g, 3'(k % 8), 1'b1);
      step();
      check($sformatf("rr%0d.c2.grant", k), 32'(bif.grant), 32'(g));
      drive_req(8'hFF & ~g);
    end
    drive_req(8'h00);
    step();
    check_outputs("rr_end", 8'h00, 3'd0, 1'b0);

    // lock: source 3 holds while source 1 waits
    drive_req(8'h08);
    step();
    check_outputs("lock.grant3", 8'h08, 3'd3, 1'b1);
    drive_req(8'h0A);
    step();
    check("lock.hold1", 32'(bif.grant), 32'h08);
    step();
    check("lock.hold2", 32'(bif.grant), 32'h08);
    drive_req(8'h02);
    step();
    check_outputs("lock.handoff", 8'h02, 3'd1, 1'b1);
    drive_req(8'h00);
    step();
    check_outputs("lock.idle", 8'h00, 3'd1, 1'b0);

    // idle hold: sel stays at the last holder
    drive_req(8'h20);
    step();
    check_outputs("idle.grant5", 8'h20, 3'd5, 1'b1);
    step();
    drive_req(8'h00);
    step();
    check_outputs("idle.drop", 8'h00, 3'd5, 1'b0);
    step();
    check("idle.sel_hold", 32'(bif.sel), 32'd5);
    check("idle.state", 32'(bif.state_dbg), 32'(ARB_IDLE));
    drive_req(8'h04);
    step();
    check_outputs("idle.grant2", 8'h04, 3'd2, 1'b1);
    drive_req(8'h00);
    step();

    // tenure: sources 0 and 4 both held high from a fresh reset
    @(negedge clk);
    do_reset();
    drive_req(8'h11);
    for (int n = 1; n <= 12; n++) begin
      step();
`ifdef BUS_ARB_TIMEOUT_EN
      g = ((((n - 1) / 4) % 2) == 0) ? 8'h01 : 8'h10;
      check($sformatf("ten%0d.grant", n), 32'(bif.grant), 32'(g));
      check($sformatf("ten%0d.preempt", n), 32'(bif.preempt),
            32'((n > 1) && (((n - 1) % 4) == 0)));
`else
      check($sformatf("ten%0d.grant", n), 32'(bif.grant), 32'h01);
      check($sformatf("ten%0d.preempt", n), 32'(bif.preempt), 32'd0);
`endif
      check($sformatf("ten%0d.grant_sel", n), 32'(bif.grant[bif.sel]), 32'd1);
    end
    drive_req(8'h00);
    step();
    check_outputs("ten.idle", 8'h00, bif.sel, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
